// File: rtl/alu_accumulator_if.sv
// Operation request bus between decode/control and the accumulator stage.
interface alu_accumulator_if #(
  parameter int WIDTH = 8
);
  logic             op_valid;
  logic             op_ready;
  logic [2:0]       op_code;
  logic [WIDTH-1:0] operand;

  modport master (output op_valid, output op_code, output operand, input  op_ready);
  modport slave  (input  op_valid, input  op_code, input  operand, output op_ready);
endinterface

// File: rtl/alu_accumulator.sv
// Accumulator/flag stage around an external ripple-carry adder: registers the
// adder operands on accept, then commits the adder result one cycle later.
module alu_accumulator #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] ACC_RESET = '0
) (
  input  logic             clk,
  input  logic             rst,
  alu_accumulator_if.slave op,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_s,
  input  logic             add_c,
  output logic [WIDTH-1:0] acc,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_n,
  output logic             flag_v,
  output logic             done
);

  localparam logic [2:0] OP_LOAD = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_ADC  = 3'd2;
  localparam logic [2:0] OP_SUB  = 3'd3;
  localparam logic [2:0] OP_SBC  = 3'd4;
  localparam logic [2:0] OP_INC  = 3'd5;
  localparam logic [2:0] OP_DEC  = 3'd6;
  localparam logic [2:0] OP_CLR  = 3'd7;

  typedef enum logic {IDLE, EXEC} state_t;

  state_t           state, state_nxt;
  logic             ready;
  logic             accept;
  logic [2:0]       opc_p0;
  logic [WIDTH-1:0] a_nxt, b_nxt;
  logic             cin_nxt;

  // Two's-complement overflow: like-signed inputs giving an opposite-signed sum.
  function automatic logic ovf(input logic signed [WIDTH-1:0] a,
                               input logic signed [WIDTH-1:0] b,
                               input logic signed [WIDTH-1:0] s);
    return (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
  endfunction

  assign op.op_ready = ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (op.op_valid) begin
          accept    = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Subtraction is a + ~b + cin, so carry-out means "no borrow".
  always_comb begin
    a_nxt   = acc;
    b_nxt   = op.operand;
    cin_nxt = 1'b0;
    case (op.op_code)
      OP_LOAD: a_nxt = '0;
      OP_ADD:  ;
      OP_ADC:  cin_nxt = flag_c;
      OP_SUB:  begin b_nxt = ~op.operand; cin_nxt = 1'b1;   end
      OP_SBC:  begin b_nxt = ~op.operand; cin_nxt = flag_c; end
      OP_INC:  begin b_nxt = '0;          cin_nxt = 1'b1;   end
      OP_DEC:  b_nxt = '1;
      OP_CLR:  begin a_nxt = '0; b_nxt = '0;                end
      default: ;
    endcase
  end

  // p0: operands registered at accept; commit stage captures adder result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      add_a   <= '0;
      add_b   <= '0;
      add_cin <= 1'b0;
      opc_p0  <= OP_LOAD;
      acc     <= ACC_RESET;
      flag_z  <= 1'b0;
      flag_c  <= 1'b0;
      flag_n  <= 1'b0;
      flag_v  <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        add_a   <= a_nxt;
        add_b   <= b_nxt;
        add_cin <= cin_nxt;
        opc_p0  <= op.op_code;
      end
      if (state == EXEC) begin
        acc    <= add_s;
        done   <= 1'b1;
        flag_z <= (add_s == '0);
        flag_n <= add_s[WIDTH-1];
        if (opc_p0 != OP_LOAD && opc_p0 != OP_CLR) begin
          flag_c <= add_c;
          flag_v <= ovf(add_a, add_b, add_s);
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_accumulator.sv
// Directed bench for alu_accumulator with a behavioural adder closing the loop.
module tb_alu_accumulator;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_accumulator_if #(.WIDTH(8)) bus ();

  logic [7:0] add_a, add_b, add_s, acc;
  logic       add_cin, add_c, flag_z, flag_c, flag_n, flag_v, done;
  logic [8:0] add_full;

  assign add_full       = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};
  assign {add_c, add_s} = add_full;

  alu_accumulator #(.WIDTH(8), .ACC_RESET(8'h00)) dut (
    .clk     (clk),
    .rst     (rst),
    .op      (bus),
    .add_a   (add_a),
    .add_b   (add_b),
    .add_cin (add_cin),
    .add_s   (add_s),
    .add_c   (add_c),
    .acc     (acc),
    .flag_z  (flag_z),
    .flag_c  (flag_c),
    .flag_n  (flag_n),
    .flag_v  (flag_v),
    .done    (done)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  localparam logic [2:0] LOAD = 3'd0, ADD = 3'd1, ADC = 3'd2, SUB = 3'd3,
                         SBC  = 3'd4, INC = 3'd5, DEC = 3'd6, CLR = 3'd7;

  // Drives one op; returns done/op_ready seen during EXEC. Ends #1 after commit edge.
  task automatic do_op(input logic [2:0] c, input logic [7:0] v,
                       output logic d_exec, output logic r_exec);
    int w;
    w = 0;
    while (!bus.op_ready && w < 10) begin
      @(posedge clk); #1; w++;
    end
    if (!bus.op_ready) begin
      n_cmp++; n_fail++;
      $display("FAIL op_ready_wait: op_ready=%b required 1", bus.op_ready);
    end
    bus.op_valid = 1'b1;
    bus.op_code  = c;
    bus.operand  = v;
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    bus.operand  = 8'hA5;
    d_exec = done;
    r_exec = bus.op_ready;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.op_valid = 1'b0; bus.op_code = 3'd0; bus.operand = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({acc, flag_z, flag_c, flag_n, flag_v, done} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_state: acc=%h zcnv=%b%b%b%b done=%b required 00/0000/0",
               acc, flag_z, flag_c, flag_n, flag_v, done);
    end
    n_cmp++;
    if ({add_a, add_b, add_cin, bus.op_ready} !== {8'h00, 8'h00, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_adder: a=%h b=%h cin=%b rdy=%b required 00 00 0 1",
               add_a, add_b, add_cin, bus.op_ready);
    end
    rst = 1'b0;
  endtask

  task automatic test_reset_mid_exec();
    @(posedge clk); #1;
    bus.op_valid = 1'b1; bus.op_code = LOAD; bus.operand = 8'h55;
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    n_cmp++;
    if (bus.op_ready !== 1'b0) begin
      n_fail++; $display("FAIL exec_not_ready: op_ready=%b required 0", bus.op_ready);
    end
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if ({acc, flag_z, flag_c, flag_n, flag_v, done, bus.op_ready} !== {8'h00, 6'b000001}) begin
      n_fail++;
      $display("FAIL rst_mid_exec: acc=%h zcnv=%b%b%b%b done=%b rdy=%b required 00 0000 0 1",
               acc, flag_z, flag_c, flag_n, flag_v, done, bus.op_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({done, bus.op_ready, acc} !== {1'b0, 1'b1, 8'h00}) begin
        n_fail++;
        $display("FAIL rst_after[%0d]: done=%b rdy=%b acc=%h required 0 1 00",
                 i, done, bus.op_ready, acc);
      end
    end
  endtask

  task automatic test_add_overflow();
    logic d, r;
    do_op(LOAD, 8'h7F, d, r);
    n_cmp++;
    if ({done, acc} !== {1'b1, 8'h7F}) begin
      n_fail++; $display("FAIL load_7f: done=%b acc=%h required 1 7f", done, acc);
    end
    do_op(ADD, 8'h01, d, r);
    n_cmp++;
    if ({d, r} !== 2'b00) begin
      n_fail++; $display("FAIL add_exec: done=%b rdy=%b required 0 0", d, r);
    end
    n_cmp++;
    if ({done, acc, flag_z, flag_c, flag_n, flag_v} !== {1'b1, 8'h80, 4'b0011}) begin
      n_fail++;
      $display("FAIL add_7f_01: done=%b acc=%h zcnv=%b%b%b%b required 1 80 0011",
               done, acc, flag_z, flag_c, flag_n, flag_v);
    end
  endtask

  task automatic test_carry_adc();
    logic d, r;
    do_op(LOAD, 8'hFF, d, r);
    do_op(ADD, 8'h01, d, r);
    n_cmp++;
    if ({acc, flag_z, flag_c, flag_n, flag_v} !== {8'h00, 4'b1100}) begin
      n_fail++;
      $display("FAIL add_ff_01: acc=%h zcnv=%b%b%b%b required 00 1100",
               acc, flag_z, flag_c, flag_n, flag_v);
    end
    do_op(ADC, 8'h00, d, r);
    n_cmp++;
    if ({acc, flag_z, flag_c, flag_n, flag_v} !== {8'h01, 4'b0000}) begin
      n_fail++;
      $display("FAIL adc_00: acc=%h zcnv=%b%b%b%b required 01 0000",
               acc, flag_z, flag_c, flag_n, flag_v);
    end
  endtask

  task automatic test_sub_sbc();
    logic d, r;
    do_op(LOAD, 8'h10, d, r);
    do_op(SUB, 8'h20, d, r);
    n_cmp++;
    if ({acc, flag_z, flag_c, flag_n, flag_v} !== {8'hF0, 4'b0010}) begin
      n_fail++;
      $display("FAIL sub_10_20: acc=%h zcnv=%b%b%b%b required f0 0010",
               acc, flag_z, flag_c, flag_n, flag_v);
    end
    do_op(SBC, 8'h0F, d, r);
    n_cmp++;
    if ({add_a, add_b, add_cin} !== {8'hF0, 8'hF0, 1'b0}) begin
      n_fail++;
      $display("FAIL sbc_operands: a=%h b=%h cin=%b required f0 f0 0", add_a, add_b, add_cin);
    end
    n_cmp++;
    if ({acc, flag_z, flag_c, flag_n, flag_v} !== {8'hE0, 4'b0110}) begin
      n_fail++;
      $display("FAIL sbc_0f: acc=%h zcnv=%b%b%b%b required e0 0110",
               acc, flag_z, flag_c, flag_n, flag_v);
    end
  endtask

  task automatic test_back_to_back();
    logic d, r;
    logic [7:0] exp_acc [4];
    exp_acc = '{8'hFF, 8'h00, 8'h01, 8'h02};
    do_op(LOAD, 8'hFE, d, r);
    bus.op_valid = 1'b1; bus.op_code = INC; bus.operand = 8'h33;
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk); #1;
      if (e == 8) bus.op_valid = 1'b0;
      n_cmp++;
      if (e % 2 == 1) begin
        if ({done, bus.op_ready} !== 2'b00) begin
          n_fail++;
          $display("FAIL b2b_exec[%0d]: done=%b rdy=%b required 0 0", e, done, bus.op_ready);
        end
      end else begin
        if ({done, bus.op_ready, acc} !== {2'b11, exp_acc[e/2-1]}) begin
          n_fail++;
          $display("FAIL b2b_commit[%0d]: done=%b rdy=%b acc=%h required 1 1 %h",
                   e, done, bus.op_ready, acc, exp_acc[e/2-1]);
        end
        if (e == 4) begin
          n_cmp++;
          if ({flag_z, flag_c} !== 2'b11) begin
            n_fail++; $display("FAIL b2b_wrap_flags: z=%b c=%b required 1 1", flag_z, flag_c);
          end
        end
      end
    end
  endtask

  task automatic test_clr_dec();
    logic d, r;
    do_op(LOAD, 8'h80, d, r);
    do_op(ADD, 8'h80, d, r);
    n_cmp++;
    if ({acc, flag_z, flag_c, flag_n, flag_v} !== {8'h00, 4'b1101}) begin
      n_fail++;
      $display("FAIL add_80_80: acc=%h zcnv=%b%b%b%b required 00 1101",
               acc, flag_z, flag_c, flag_n, flag_v);
    end
    do_op(CLR, 8'h5A, d, r);
    n_cmp++;
    if ({acc, flag_z, flag_c, flag_n, flag_v} !== {8'h00, 4'b1101}) begin
      n_fail++;
      $display("FAIL clr_hold: acc=%h zcnv=%b%b%b%b required 00 1101",
               acc, flag_z, flag_c, flag_n, flag_v);
    end
    do_op(DEC, 8'h00, d, r);
    n_cmp++;
    if ({acc, flag_z, flag_c, flag_n, flag_v} !== {8'hFF, 4'b0010}) begin
      n_fail++;
      $display("FAIL dec_00: acc=%h zcnv=%b%b%b%b required ff 0010",
               acc, flag_z, flag_c, flag_n, flag_v);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({done, bus.op_ready} !== 2'b01) begin
      n_fail++; $display("FAIL idle_after: done=%b rdy=%b required 0 1", done, bus.op_ready);
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_exec();
    test_add_overflow();
    test_carry_adc();
    test_sub_sbc();
    test_back_to_back();
    test_clr_dec();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_accumulator.md
Name: alu_accumulator

Overview:
- Sequencing and result-capture stage wrapped around the 8-bit ripple-carry adder.
- Registers the adder operands (a, b, cin) from the accumulator and an incoming operand, then captures the adder sum/carry back into the accumulator and a Z/C/N/V flag register.
- Sits between the instruction decode/control logic (upstream, valid/ready handshake) and the combinational adder (downstream of its operand registers, upstream of its result).

Parameters:
WIDTH, 8, datapath width; must equal adder width
ACC_RESET, 8'h00, accumulator value after reset

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-high reset
op_valid  input  1  operation request
op_ready  output  1  block can accept an operation
op_code  input  3  0 LOAD, 1 ADD, 2 ADC, 3 SUB, 4 SBC, 5 INC, 6 DEC, 7 CLR
operand  input  WIDTH  second operand
add_a  output  WIDTH  to adder input a
add_b  output  WIDTH  to adder input b
add_cin  output  1  to adder cin
add_s  input  WIDTH  from adder sum s
add_c  input  1  from adder carry-out c
acc  output  WIDTH  accumulator value
flag_z, flag_c, flag_n, flag_v  output  1 each  zero, carry, negative, overflow
done  output  1  one-cycle pulse: result committed

Behaviour:
- Reset (async, any state, including mid-operation):
  - state = IDLE; acc = ACC_RESET.
  - All flags = 0; add_a/add_b/add_cin = 0; done = 0.
  - Any in-flight operation is dropped.
- FSM has two states:
  - IDLE: op_ready = 1.
  - EXEC: op_ready = 0; op_valid is ignored.
- Accept edge: rising edge with op_valid && op_ready.
  - Register add_a/add_b/add_cin per the operation mapping below.
  - Latch op_code internally; state goes to EXEC.
- EXEC edge (next edge):
  - Capture acc = add_s and update flags per the rules below.
  - done = 1 for exactly this following cycle; state returns to IDLE.
- Latency and throughput:
  - Accept at edge k, commit at edge k+1; done is high during the cycle after edge k+1.
  - op_ready is high in that same cycle, so the next accept is at edge k+2.
  - Sustained throughput is one op per 2 cycles.
- Operation mapping (add_a, add_b, add_cin):
  - LOAD: 0, operand, 0
  - ADD: acc, operand, 0
  - ADC: acc, operand, flag_c
  - SUB: acc, ~operand, 1
  - SBC: acc, ~operand, flag_c
  - INC: acc, 0, 1
  - DEC: acc, all-ones, 0
  - CLR: 0, 0, 0
- Operand sampling:
  - flag_c and acc are sampled at the accept edge.
  - operand is not needed after the accept edge.
- Flag rules, computed from add_a/add_b/add_s/add_c during EXEC:
  - Z = (add_s == 0).
  - N = add_s[WIDTH-1].
  - C = add_c. For SUB/SBC this means C = 1 when there is no borrow.
  - V = (add_a[MSB] == add_b[MSB]) && (add_s[MSB] != add_a[MSB]).
  - LOAD and CLR update Z and N only; C and V hold.
  - All arithmetic ops update Z, C, N and V.
- Wrap-around is modulo 2^WIDTH and needs no special handling: 8'hFF + 1 gives 8'h00 with C = 1.
- add_a/add_b/add_cin hold their values from the accept edge until the next accept edge (stable for the adder across EXEC).
- Illegal values: none; all 8 op_codes are defined.
- done and op_ready are never both low while in IDLE.

Test Plan:
- Reset mid-EXEC: LOAD 8'h55 accepted, assert rst during EXEC -> acc = 8'h00, flags 0, done never pulses, op_ready = 1 after release.
- LOAD 8'h7F then ADD 8'h01 -> acc = 8'h80, N = 1, V = 1, C = 0, Z = 0; done pulses once per op, 2 cycles apart.
- LOAD 8'hFF, ADD 8'h01 -> acc = 8'h00, Z = 1, C = 1, V = 0. Then ADC 8'h00 -> acc = 8'h01, C = 0.
- LOAD 8'h10, SUB 8'h20 -> acc = 8'hF0, C = 0 (borrow), N = 1. Then SBC 8'h0F -> add_cin = 0, acc = 8'hE0, C = 1.
- Back-to-back: hold op_valid high with INC for 4 ops from acc = 8'hFE -> accepts spaced 2 cycles, op_ready low in EXEC, acc sequence FF, 00 (Z = 1, C = 1), 01, 02.
- CLR after ADD set C = 1 -> acc = 00, Z = 1, N = 0, C stays 1, V unchanged; DEC from 00 -> acc = FF, C = 0, N = 1.
